// File: rtl/serial_fifo_port_pkg.sv
// Shared definitions for the buffered serial port: register map,
// STATUS/CTRL bit positions and the value returned by an empty DATA read.
package serial_fifo_port_pkg;

   // Word offsets inside the three-register window
   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2
   } reg_sel_e;

   localparam logic [31:0] WINDOW_WORDS = 32'd3;

   // STATUS read layout
   localparam int ST_RX_NONEMPTY = 0;
   localparam int ST_TX_FULL     = 1;
   localparam int ST_TX_EMPTY    = 2;
   localparam int ST_TX_DROP     = 3;
   localparam int ST_RX_COUNT    = 8;
   localparam int ST_TX_COUNT    = 16;

   // CTRL write layout
   localparam int CTRL_FLUSH_TX = 0;
   localparam int CTRL_FLUSH_RX = 1;

   // Returned by a DATA read while the RX FIFO is empty
   localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy counter. The head entry is visible
// combinationally on pop_data. A push into a full FIFO is accepted when a
// pop happens in the same cycle; flush overrides any push or pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_MAX);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Pops only take effect on real data; a pop frees the slot a full push needs
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Next-state for storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; storage contents need no reset since count gates them
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/serial_fifo_port.sv
// Memory-mapped serial port with independent TX and RX FIFOs. Decodes a
// three-word window at BASE: DATA (push TX / pop RX), STATUS, CTRL (flush).
module serial_fifo_port
   import serial_fifo_port_pkg::*;
#(
   parameter logic [31:0] BASE  = 32'd32,
   parameter int          WIDTH = 8,
   parameter int          DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             rw,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             rdata_valid,
   output logic [WIDTH-1:0] tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   input  logic [WIDTH-1:0] rx_data,
   input  logic             rx_valid,
   output logic             rx_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   // Bus decode
   logic [31:0] offset;
   logic        in_range;
   reg_sel_e    reg_sel;
   logic        data_wr, data_rd, status_wr, status_rd, ctrl_wr;

   // FIFO hookup
   logic             tx_push, tx_pop, tx_flush, tx_full, tx_empty;
   logic [CW-1:0]    tx_count;
   logic             rx_push, rx_pop, rx_flush, rx_full, rx_empty;
   logic [CW-1:0]    rx_count;
   logic [WIDTH-1:0] rx_head;

   // Registered state
   logic [31:0] rdata_q, rdata_d;
   logic        rdata_valid_q, rdata_valid_d;
   logic        tx_drop_q, tx_drop_d;
   logic [31:0] status_word;

   // Only the low WIDTH bits and a few control bits of wdata are meaningful
   logic unused_wdata;
   assign unused_wdata = ^wdata;

   // Wrapping subtraction makes addresses below BASE land far outside the window
   assign offset    = addr - BASE;
   assign in_range  = enable && (offset < WINDOW_WORDS);
   assign reg_sel   = reg_sel_e'(offset[1:0]);
   assign data_wr   = in_range &&  rw && (reg_sel == REG_DATA);
   assign data_rd   = in_range && !rw && (reg_sel == REG_DATA);
   assign status_wr = in_range &&  rw && (reg_sel == REG_STATUS);
   assign status_rd = in_range && !rw && (reg_sel == REG_STATUS);
   assign ctrl_wr   = in_range &&  rw && (reg_sel == REG_CTRL);

   assign tx_push  = data_wr;
   assign tx_pop   = tx_ready && !tx_empty;
   assign tx_flush = ctrl_wr && wdata[CTRL_FLUSH_TX];
   assign rx_push  = rx_valid && !rx_full;
   assign rx_pop   = data_rd && !rx_empty;
   assign rx_flush = ctrl_wr && wdata[CTRL_FLUSH_RX];

   assign tx_valid    = !tx_empty;
   assign rx_ready    = !rx_full;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tx_push),
      .push_data (wdata[WIDTH-1:0]),
      .pop       (tx_pop),
      .flush     (tx_flush),
      .pop_data  (tx_data),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_push),
      .push_data (rx_data),
      .pop       (rx_pop),
      .flush     (rx_flush),
      .pop_data  (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   // STATUS word assembled from the current (pre-access) FIFO state
   always_comb begin
      status_word                        = '0;
      status_word[ST_RX_NONEMPTY]        = !rx_empty;
      status_word[ST_TX_FULL]            = tx_full;
      status_word[ST_TX_EMPTY]           = tx_empty;
      status_word[ST_TX_DROP]            = tx_drop_q;
      status_word[ST_RX_COUNT +: CW]     = rx_count;
      status_word[ST_TX_COUNT +: CW]     = tx_count;
   end

   // Read data mux, read strobe and the sticky drop flag
   always_comb begin
      rdata_d       = rdata_q;
      rdata_valid_d = data_rd || status_rd || (in_range && !rw && reg_sel == REG_CTRL);
      tx_drop_d     = tx_drop_q;
      if (data_rd) begin
         if (rx_empty) begin
            rdata_d = EMPTY_READ;
         end else begin
            rdata_d              = '0;
            rdata_d[WIDTH-1:0]   = rx_head;
         end
      end else if (status_rd) begin
         rdata_d = status_word;
      end else if (rdata_valid_d) begin
         rdata_d = '0;
      end
      // A push only drops when full and the sink is not freeing a slot
      if (data_wr && tx_full && !tx_pop) begin
         tx_drop_d = 1'b1;
      end
      if (status_wr && wdata[ST_TX_DROP]) begin
         tx_drop_d = 1'b0;
      end
   end

   // Bus-side registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         tx_drop_q     <= 1'b0;
      end else begin
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         tx_drop_q     <= tx_drop_d;
      end
   end

endmodule

// File: tb/tb_serial_fifo_port.sv
// Bench for serial_fifo_port: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_serial_fifo_port;

   localparam logic [31:0] BASE  = 32'd32;
   localparam int          WIDTH = 8;
   localparam int          DEPTH = 4;
   localparam int          CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             rw;
   logic [31:0]      addr;
   logic [31:0]      wdata;
   logic [31:0]      rdata;
   logic             rdata_valid;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             rx_ready;

   int n_checks = 0;
   int n_errors = 0;

   serial_fifo_port #(.BASE(BASE), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .rw          (rw),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] tq[$];
   logic [WIDTH-1:0] rq[$];
   logic [WIDTH-1:0] sink_q[$];
   logic             m_drop  = 1'b0;
   logic [31:0]      m_rdata = '0;
   logic             m_rv    = 1'b0;
   bit               m_live  = 1'b0;

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = '0;
      s[0] = (rq.size() != 0);
      s[1] = (tq.size() == DEPTH);
      s[2] = (tq.size() == 0);
      s[3] = m_drop;
      s[8 +: CW]  = CW'(rq.size());
      s[16 +: CW] = CW'(tq.size());
      return s;
   endfunction

   task automatic model_step();
      logic [31:0] off;
      bit          rd, wr, rx_pop;
      logic [31:0] val;
      off    = addr - BASE;
      rd     = enable && (off < 3) && !rw;
      wr     = enable && (off < 3) && rw;
      rx_pop = 1'b0;
      val    = '0;
      if (rd) begin
         if (off == 0) begin
            if (rq.size() > 0) begin
               val    = 32'(rq[0]);
               rx_pop = 1'b1;
            end else begin
               val = 32'hFFFF_FFFF;
            end
         end else if (off == 1) begin
            val = m_status();
         end
      end
      // sink side first, so a same-cycle pop makes room for the push
      if (tx_ready && tq.size() > 0) void'(tq.pop_front());
      if (wr && off == 0) begin
         if (tq.size() < DEPTH) tq.push_back(wdata[WIDTH-1:0]);
         else m_drop = 1'b1;
      end
      if (wr && off == 1 && wdata[3]) m_drop = 1'b0;
      begin
         bit can_rx;
         can_rx = rx_valid && (rq.size() < DEPTH);
         if (rx_pop) void'(rq.pop_front());
         if (can_rx) rq.push_back(rx_data);
      end
      if (wr && off == 2) begin
         if (wdata[0]) tq.delete();
         if (wdata[1]) rq.delete();
      end
      m_rv = rd;
      if (rd) m_rdata = val;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            tq.delete();
            rq.delete();
            m_drop  = 1'b0;
            m_rdata = '0;
            m_rv    = 1'b0;
            m_live  = 1'b1;
         end else if (m_live) begin
            model_step();
         end
      end
   end

   // Compare process plus sink monitor, both away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (m_live) begin
            check("rdata_valid", 32'(rdata_valid), 32'(m_rv));
            check("rdata", rdata, m_rdata);
            check("tx_valid", 32'(tx_valid), 32'(tq.size() != 0));
            check("rx_ready", 32'(rx_ready), 32'(rq.size() < DEPTH));
            if (tq.size() != 0) check("tx_data", 32'(tx_data), 32'(tq[0]));
         end
         if (tx_valid && tx_ready) sink_q.push_back(tx_data);
      end
   end

   // ---------------- bus helpers (called at posedge+1) ----------------
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      enable = 1'b1; rw = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      enable = 1'b0; rw = 1'b0;
      $display("bus write addr=%0d data=%h", a, d);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      enable = 1'b1; rw = 1'b0; addr = a;
      @(posedge clk); #1;
      enable = 1'b0;
      d = rdata;
      $display("bus read  addr=%0d data=%h valid=%0b", a, d, rdata_valid);
   endtask

   task automatic read_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check({name, "_valid"}, 32'(rdata_valid), 32'd1);
      check(name, d, exp);
   endtask

   initial begin
      logic [31:0] d;
      int          acc;
      logic        was_ready;

      reset = 1'b1; enable = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      check("rx_ready_after_reset", 32'(rx_ready), 32'd1);
      read_expect("status_reset", BASE + 1, 32'h0000_0004);

      // Out-of-range accesses do nothing
      bus_read(BASE + 3, d);
      check("oor_read_valid", 32'(rdata_valid), 32'd0);
      bus_write(BASE - 1, 32'h55);
      check("oor_write_tx_valid", 32'(tx_valid), 32'd0);

      // Fill TX, overflow sets the sticky drop flag
      bus_write(BASE, 32'h41);
      bus_write(BASE, 32'h42);
      bus_write(BASE, 32'h43);
      bus_write(BASE, 32'h44);
      read_expect("status_tx_full", BASE + 1, 32'h0004_0002);
      bus_write(BASE, 32'h45);
      read_expect("status_tx_drop", BASE + 1, 32'h0004_000A);
      tx_ready = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      tx_ready = 1'b0;
      check("sink_count", 32'(sink_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < sink_q.size(); i++)
         check("sink_char", 32'(sink_q[i]), 32'h41 + 32'(i));
      read_expect("status_drained_drop", BASE + 1, 32'h0000_000C);

      // RX fills to DEPTH, then backpressure
      acc = 0;
      rx_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rx_data   = 8'h31 + 8'(acc);
         was_ready = rx_ready;
         @(posedge clk); #1;
         if (was_ready) acc++;
      end
      check("rx_accepted", 32'(acc), 32'd4);
      check("rx_ready_full", 32'(rx_ready), 32'd0);
      rx_valid = 1'b0;
      read_expect("status_rx_full", BASE + 1, 32'h0000_040D);
      for (int i = 0; i < 4; i++)
         read_expect("rx_pop", BASE, 32'h31 + 32'(i));
      rx_valid = 1'b1; rx_data = 8'h35;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      read_expect("rx_pop_5th", BASE, 32'h35);
      read_expect("rx_empty_read", BASE, 32'hFFFF_FFFF);

      // Clear drop, then push-while-full with the sink popping the same cycle
      bus_write(BASE + 1, 32'h8);
      read_expect("status_drop_clear", BASE + 1, 32'h0000_0004);
      bus_write(BASE, 32'h61);
      bus_write(BASE, 32'h62);
      bus_write(BASE, 32'h63);
      bus_write(BASE, 32'h64);
      tx_ready = 1'b1;
      bus_write(BASE, 32'h5A);
      tx_ready = 1'b0;
      read_expect("status_full_pop_push", BASE + 1, 32'h0004_0002);
      check("sink_last", 32'(sink_q[sink_q.size() - 1]), 32'h61);

      // Flush both FIFOs while both hold data
      rx_valid = 1'b1; rx_data = 8'h70;
      @(posedge clk); #1;
      rx_data = 8'h71;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      read_expect("status_both", BASE + 1, 32'h0004_0203);
      bus_write(BASE + 2, 32'h3);
      read_expect("status_flushed", BASE + 1, 32'h0000_0004);

      // Reset mid-operation with a read in the reset cycle
      bus_write(BASE, 32'h01);
      bus_write(BASE, 32'h02);
      bus_write(BASE, 32'h03);
      read_expect("status_tx3", BASE + 1, 32'h0003_0000);
      reset = 1'b1; enable = 1'b1; rw = 1'b0; addr = BASE + 1;
      @(posedge clk); #1;
      reset = 1'b0; enable = 1'b0;
      check("reset_read_valid", 32'(rdata_valid), 32'd0);
      check("reset_tx_valid", 32'(tx_valid), 32'd0);
      read_expect("status_after_reset", BASE + 1, 32'h0000_0004);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         reset    = ($urandom_range(0, 399) == 0);
         enable   = $urandom_range(0, 1);
         rw       = $urandom_range(0, 1);
         addr     = BASE - 1 + 32'($urandom_range(0, 4));
         if (addr == BASE + 2)
            wdata = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 32'h0;
         else
            wdata = $urandom;
         tx_ready = ($urandom_range(0, 2) == 0);
         rx_valid = $urandom_range(0, 1);
         rx_data  = 8'($urandom);
         @(posedge clk); #1;
         if (c % 500 == 499) $display("random burst done at cycle %0d", c + 1);
      end
      reset = 1'b0; enable = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
